// File: rtl/seg7_driver_pkg.sv
// Shared constants and payload types for the 8-digit multiplexed 7-segment driver.
package seg7_driver_pkg;

  localparam int unsigned SCAN_MAX_DEF  = 32'd100000;
  localparam int unsigned BLANK_CYC_DEF = 32'd100;

  // Glyphs as {a,b,c,d,e,f,g,dp}, dp always clear here
  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  typedef struct packed {
    logic [7:0] blank;
    logic [7:0] dp;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] data;
    ctrl_t       ctrl;
  } disp_t;

  localparam disp_t DISP_RESET = '{data: 32'h0, ctrl: '{blank: 8'hFF, dp: 8'h00}};

endpackage

// File: rtl/seg7_driver_decode.sv
// Combinational hex nibble to 7-segment glyph decoder (dp bit left clear).
module seg7_decode
  import seg7_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] glyph_c
);

  always_comb begin
    glyph_c = GLYPH_0;
    case (nibble)
      4'h0: glyph_c = GLYPH_0;
      4'h1: glyph_c = GLYPH_1;
      4'h2: glyph_c = GLYPH_2;
      4'h3: glyph_c = GLYPH_3;
      4'h4: glyph_c = GLYPH_4;
      4'h5: glyph_c = GLYPH_5;
      4'h6: glyph_c = GLYPH_6;
      4'h7: glyph_c = GLYPH_7;
      4'h8: glyph_c = GLYPH_8;
      4'h9: glyph_c = GLYPH_9;
      4'hA: glyph_c = GLYPH_A;
      4'hB: glyph_c = GLYPH_B;
      4'hC: glyph_c = GLYPH_C;
      4'hD: glyph_c = GLYPH_D;
      4'hE: glyph_c = GLYPH_E;
      4'hF: glyph_c = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_driver.sv
// Scans 8 hex digits as two groups of four, with frame-synchronous shadow commit
// so a frame never shows a mix of old and new data.
module seg7_driver
  import seg7_driver_pkg::*;
#(
  parameter int unsigned SCAN_MAX  = SCAN_MAX_DEF,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_we,
  input  logic [31:0] data_in,
  input  logic        ctrl_we,
  input  logic [15:0] ctrl_in,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out0,
  output logic [7:0]  seg_out1,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  disp_t            pend, pend_nxt, disp;
  logic             frame_end_c;
  logic [2:0]       lo_d, hi_d;
  logic [3:0]       lo_nib, hi_nib;
  logic [7:0]       lo_glyph_c, hi_glyph_c;
  logic [7:0]       en_nxt, out0_nxt, out1_nxt;

  assign frame_end_c = (idx == 2'd3) && (cnt == CNT_W'(SCAN_MAX - 1));

  // Slot timer: cnt within slot, idx selects digit pair (idx, idx+4)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(SCAN_MAX - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A strobe in the frame-end cycle is folded in before the commit
  always_comb begin
    pend_nxt = pend;
    if (data_we) pend_nxt.data = data_in;
    if (ctrl_we) pend_nxt.ctrl = ctrl_t'(ctrl_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= DISP_RESET;
      disp <= DISP_RESET;
    end else begin
      pend <= pend_nxt;
      if (frame_end_c) disp <= pend_nxt;
    end
  end

  assign lo_d   = {1'b0, idx};
  assign hi_d   = {1'b1, idx};
  assign lo_nib = disp.data[{1'b0, idx, 2'b00} +: 4];
  assign hi_nib = disp.data[{1'b1, idx, 2'b00} +: 4];

  seg7_decode u_dec_lo (.nibble(lo_nib), .glyph_c(lo_glyph_c));
  seg7_decode u_dec_hi (.nibble(hi_nib), .glyph_c(hi_glyph_c));

  always_comb begin
    en_nxt   = '0;
    out0_nxt = '0;
    out1_nxt = '0;
    if (cnt >= CNT_W'(BLANK_CYC)) begin
      en_nxt[lo_d] = ~disp.ctrl.blank[lo_d];
      en_nxt[hi_d] = ~disp.ctrl.blank[hi_d];
    end
    if (!disp.ctrl.blank[lo_d]) out0_nxt = lo_glyph_c | {7'b0, disp.ctrl.dp[lo_d]};
    if (!disp.ctrl.blank[hi_d]) out1_nxt = hi_glyph_c | {7'b0, disp.ctrl.dp[hi_d]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en     <= '0;
      seg_out0   <= '0;
      seg_out1   <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_en     <= en_nxt;
      seg_out0   <= out0_nxt;
      seg_out1   <= out1_nxt;
      frame_tick <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg7_driver.sv
// Randomized scoreboard bench for seg7_driver with a cycle-indexed reference model.
module tb_seg7_driver;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SCAN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_we = 1'b0;
  logic [31:0] data_in = '0;
  logic        ctrl_we = 1'b0;
  logic [15:0] ctrl_in = '0;
  logic [7:0]  seg_en, seg_out0, seg_out1;
  logic        frame_tick;

  seg7_driver #(.SCAN_MAX(SCAN), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst),
    .data_we(data_we), .data_in(data_in),
    .ctrl_we(ctrl_we), .ctrl_in(ctrl_in),
    .seg_en(seg_en), .seg_out0(seg_out0), .seg_out1(seg_out1),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] en;
    logic [7:0] o0;
    logic [7:0] o1;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;

  // Standard glyphs {a,b,c,d,e,f,g,dp}
  logic [7:0] gtab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model state: k = clock edges since reset released
  int          k = 0;
  logic [31:0] p_data = '0, d_data = '0;
  logic [15:0] p_ctrl = 16'hFF00, d_ctrl = 16'hFF00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t model_out(input int c, input int s, input logic [31:0] d,
                                     input logic [15:0] ctl);
    exp_t e;
    logic [7:0] bm, dpm;
    bm  = ctl[15:8];
    dpm = ctl[7:0];
    e = '0;
    if (c >= BLANK) begin
      e.en[s]   = !bm[s];
      e.en[s+4] = !bm[s+4];
    end
    e.o0 = bm[s]   ? 8'h00 : (gtab[d[4*s +: 4]]     | {7'b0, dpm[s]});
    e.o1 = bm[s+4] ? 8'h00 : (gtab[d[4*(s+4) +: 4]] | {7'b0, dpm[s+4]});
    return e;
  endfunction

  // Reference model: predicts the outputs presented after each edge
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      k = 0;
      p_data = '0; d_data = '0;
      p_ctrl = 16'hFF00; d_ctrl = 16'hFF00;
      q.push_back('0);
    end else begin
      e = model_out(k % SCAN, (k / SCAN) % 4, d_data, d_ctrl);
      e.ft = ((k % FRAME) == FRAME - 1);
      q.push_back(e);
      if (data_we) p_data = data_in;
      if (ctrl_we) p_ctrl = ctrl_in;
      if ((k % FRAME) == FRAME - 1) begin
        d_data = p_data;
        d_ctrl = p_ctrl;
      end
      k++;
    end
  end

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL sb_underflow: got 0 queued expectations, required 1 at %0t", $time);
    end else begin
      e = q.pop_front();
      if (rst) e = '0;
      check("sb_seg_en",     32'(seg_en),     32'(e.en));
      check("sb_seg_out0",   32'(seg_out0),   32'(e.o0));
      check("sb_seg_out1",   32'(seg_out1),   32'(e.o1));
      check("sb_frame_tick", 32'(frame_tick), 32'(e.ft));
    end
  end

  task automatic wait_k(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((k % FRAME) != target) && (n < 4 * FRAME));
    if ((k % FRAME) != target) begin
      n_total++;
      $display("FAIL wait_timeout: got phase %0d required %0d", k % FRAME, target);
    end
  endtask

  task automatic write(input logic dw, input logic [31:0] d, input logic cw, input logic [15:0] c);
    data_we = dw; data_in = d;
    ctrl_we = cw; ctrl_in = c;
    @(negedge clk);
    data_we = 1'b0;
    ctrl_we = 1'b0;
  endtask

  logic [31:0] rnd;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_seg_en", 32'(seg_en), 32'h0);
    check("reset_seg_out0", 32'(seg_out0), 32'h0);
    #1 rst = 1'b0;

    // Dark display with no writes; frame ticks every 32 cycles
    repeat (70) @(negedge clk);
    check("dark_seg_en", 32'(seg_en), 32'h0);

    // Data plus ctrl in one cycle, mid-frame
    wait_k(5);
    write(1'b1, 32'h76543210, 1'b1, 16'h0000);
    wait_k(1);
    check("slot0_blank_en", 32'(seg_en), 32'h00);
    wait_k(4);
    check("slot0_en", 32'(seg_en), 32'h11);
    check("slot0_out0", 32'(seg_out0), 32'hFC);
    check("slot0_out1", 32'(seg_out1), 32'h66);

    // Mid-frame write must not disturb the current frame
    wait_k(10);
    write(1'b1, $urandom, 1'b0, 16'h0);
    repeat (2 * FRAME) @(negedge clk);

    // Write exactly on the frame-end cycle commits at that boundary
    rnd = $urandom;
    wait_k(31);
    write(1'b1, rnd, 1'b0, 16'h0);
    wait_k(4);
    check("frame_end_out0", 32'(seg_out0), 32'(gtab[rnd[3:0]]));
    check("frame_end_out1", 32'(seg_out1), 32'(gtab[rnd[19:16]]));

    // Blank digits 0-3, dp requested on blanked digit 0
    wait_k(5);
    write(1'b0, 32'h0, 1'b1, 16'h0F01);
    wait_k(4);
    check("blank_en", 32'(seg_en), 32'h10);
    check("blank_out0", 32'(seg_out0), 32'h00);
    check("blank_out1", 32'(seg_out1), 32'(gtab[rnd[19:16]]));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      data_we = ($urandom_range(0, 7) == 0);
      data_in = $urandom;
      ctrl_we = ($urandom_range(0, 9) == 0);
      ctrl_in = 16'($urandom);
      @(negedge clk);
    end
    data_we = 1'b0;
    ctrl_we = 1'b0;

    // Reset asserted mid-slot 2
    wait_k(2 * SCAN + 3);
    #1 rst = 1'b1;
    #1;
    check("rst_seg_en", 32'(seg_en), 32'h0);
    check("rst_seg_out0", 32'(seg_out0), 32'h0);
    check("rst_seg_out1", 32'(seg_out1), 32'h0);
    check("rst_frame_tick", 32'(frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_k(4);
    check("post_rst_en", 32'(seg_en), 32'h0);
    check("post_rst_out0", 32'(seg_out0), 32'h0);

    // Recover after reset
    wait_k(5);
    write(1'b1, 32'hFEDCBA98, 1'b1, 16'h0080);
    wait_k(4);
    check("recover_en", 32'(seg_en), 32'h11);
    check("recover_out0", 32'(seg_out0), 32'hFE);
    repeat (3 * SCAN) @(negedge clk);
    check("recover_slot3_out1", 32'(seg_out1), 32'(8'h8E | 8'h01));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_driver.md
SEG7_DRIVER -- requirements
Module: seg7_driver

Interface
REQ-001 SHALL have parameter SCAN_MAX, default 32'd100000, giving clock cycles per scan slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 32'd100, giving leading inter-digit blanking cycles per slot; BLANK_CYC < SCAN_MAX.
REQ-003 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port data_we, input, 1, single-cycle write strobe for data_in.
REQ-006 SHALL have port data_in, input, 32, eight hex nibbles; nibble k = data_in[4k+3:4k] drives digit k.
REQ-007 SHALL have port ctrl_we, input, 1, single-cycle write strobe for ctrl_in.
REQ-008 SHALL have port ctrl_in, input, 16, [15:8] blank mask (1 = digit dark), [7:0] decimal-point mask (1 = dp lit).
REQ-009 SHALL have port seg_en, output, 8, active-high digit enables; bit k = digit k.
REQ-010 SHALL have port seg_out0, output, 8, active-high segments for digits 0-3; {a,b,c,d,e,f,g,dp} = bits [7:0].
REQ-011 SHALL have port seg_out1, output, 8, active-high segments for digits 4-7, same encoding.
REQ-012 SHALL have port frame_tick, output, 1, one-cycle pulse at each completed 4-slot frame.

Function
REQ-013 SHALL hold a cycle counter cnt counting 0..SCAN_MAX-1, wrapping to 0, advancing slot index idx (2 bits, 0..3, 3 wraps to 0) on wrap.
REQ-014 SHALL, in slot idx, select digit idx on seg_out0 and digit idx+4 on seg_out1.
REQ-015 SHALL drive seg_en = 0 while cnt < BLANK_CYC, else bits idx and idx+4 set, each cleared when its blank-mask bit is 1.
REQ-016 SHALL drive seg_outN = 0 for a blanked digit, else the hex-decoded nibble with dp = dp-mask bit.
REQ-017 SHALL register all outputs: outputs reflect cnt/idx/display state of the preceding clock edge (latency 1).
REQ-018 SHALL hex-decode 0-F to standard glyphs (0 = 8'hFC, 1 = 8'h60, 8 = 8'hFE, F = 8'h8E, dp excluded).
REQ-019 SHALL capture data_in / ctrl_in into pending (shadow) registers on their strobe; last write before commit wins.
REQ-020 SHALL copy pending to display registers only at frame end (idx == 3 and cnt == SCAN_MAX-1), so no frame shows mixed data.
REQ-021 SHALL, when a strobe coincides with the frame-end cycle, commit the newly written value directly at that boundary.
REQ-022 SHALL assert frame_tick for exactly one cycle, on the cycle after the frame-end cycle.
REQ-023 SHALL accept data_we and ctrl_we in the same cycle independently.

Reset
REQ-024 SHALL, on rst asserted (any time, mid-slot included), immediately force cnt = 0, idx = 0, seg_en = 0, seg_out0 = seg_out1 = 0, frame_tick = 0.
REQ-025 SHALL reset pending and display data to 32'h0, dp masks to 8'h00, blank masks to 8'hFF (display dark until first ctrl write commits).
REQ-026 SHALL resume scanning from slot 0, cnt 0, on the first edge after rst deasserts.

Structure
REQ-027 SHALL place segment glyph constants and default SCAN_MAX/BLANK_CYC in the shared IO package/header.
REQ-028 SHALL implement nibble-to-glyph conversion as combinational sub-module seg7_decode, instantiated twice (one per group).
REQ-029 SHALL keep counter, shadow/commit logic and output registers in seg7_driver; no other sub-modules.

Verification (SCAN_MAX=8, BLANK_CYC=2)
REQ-030 Reset released, no writes -> seg_en = 0, seg_out0 = seg_out1 = 0 for full frames; frame_tick every 32 cycles.
REQ-031 data_in 32'h76543210, ctrl_in 16'h0000, wait frame -> slot 0: seg_en 8'h11, seg_out0 8'hFC, seg_out1 glyph 4; cycles 0-1 of each slot seg_en = 0.
REQ-032 Write data mid-frame -> display unchanged until cycle after frame end; next frame fully new data, never mixed.
REQ-033 data_we on exact frame-end cycle -> new data shown from first slot of next frame.
REQ-034 ctrl_in 16'h0F01 -> digits 0-3 never enabled; digit 0 dp not visible (blanked); digit 4 glyph without dp.
REQ-035 rst asserted mid-slot 2 -> outputs zero same edge-independent; after release scan restarts at slot 0, blank masks 8'hFF.
